// File: rtl/gpio_bus_pkg.sv
// Shared types and default timing constants for the GPIO pad-bus transaction scheduler.
package gpio_bus_pkg;

   localparam int DEFAULT_W             = 34;
   localparam int DEFAULT_STROBE_CYCLES = 2;
   localparam int DEFAULT_TURN_CYCLES   = 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_TURN,
      ST_STROBE,
      ST_HOLD
   } state_e;

   typedef enum logic {
      PORT_A = 1'b0,
      PORT_B = 1'b1
   } port_e;

endpackage

// File: rtl/gpio_bus_rr_arb.sv
// Two-way round-robin arbiter: one-hot grant while enabled, plus the port granted last.
module gpio_bus_rr_arb
   import gpio_bus_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       en,
   output logic [1:0] gnt,
   output port_e      last_gnt
);

   // NOTE: gnt gets its default before any branch, so no path leaves it unassigned (no latch).
   always_comb begin
      gnt = 2'b00;
      if (en) begin
         if (req == 2'b11) gnt = (last_gnt == PORT_B) ? 2'b01 : 2'b10;
         else              gnt = req;
      end
   end

   // NOTE: flops use <= so every register samples the values from before the edge.
   always_ff @(posedge clk) begin
      if (rst)         last_gnt <= PORT_B;
      else if (gnt[0]) last_gnt <= PORT_A;
      else if (gnt[1]) last_gnt <= PORT_B;
   end

endmodule

// File: rtl/gpio_bus_sched.sv
// Round-robin scheduler for two single-word requesters sharing the GPIO pad bus,
// sequencing the web/oeb strobes, pad direction and turnaround/hold timing.
module gpio_bus_sched
   import gpio_bus_pkg::*;
#(
   parameter int W             = DEFAULT_W,
   parameter int STROBE_CYCLES = DEFAULT_STROBE_CYCLES,
   parameter int TURN_CYCLES   = DEFAULT_TURN_CYCLES
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         a_req_i,
   input  logic         a_we_i,
   input  logic [W-1:0] a_wdata_i,
   output logic         a_ack_o,
   output logic [W-1:0] a_rdata_o,
   input  logic         b_req_i,
   input  logic         b_we_i,
   input  logic [W-1:0] b_wdata_i,
   output logic         b_ack_o,
   output logic [W-1:0] b_rdata_o,
   input  logic [W-1:0] bus_di_i,
   output logic [W-1:0] bus_do_o,
   output logic         bus_oe_o,
   output logic         web_o,
   output logic         oeb_o
);

   localparam int MAX_CYCLES = (STROBE_CYCLES > TURN_CYCLES) ? STROBE_CYCLES : TURN_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
   localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_CYCLES - 1);
   localparam logic [CNT_W-1:0] TURN_LOAD   = CNT_W'(TURN_CYCLES - 1);

   state_e           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             cur_we, cur_we_nxt;
   logic [1:0]       gnt;
   port_e            cur_port;
   logic             oe_nxt, web_nxt, oeb_nxt, a_ack_nxt, b_ack_nxt;
   logic             sample_rd;

   // The last-grant register doubles as the owner of the transaction in flight.
   gpio_bus_rr_arb u_arb (
      .clk      (clk_i),
      .rst      (rst_i),
      .req      ({b_req_i, a_req_i}),
      .en       (state == ST_IDLE),
      .gnt      (gnt),
      .last_gnt (cur_port)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         cur_we <= 1'b0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         cur_we <= cur_we_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      cur_we_nxt = cur_we;
      case (state)
         ST_IDLE: begin
            if (gnt[0])      cur_we_nxt = a_we_i;
            else if (gnt[1]) cur_we_nxt = b_we_i;
            if (gnt != 2'b00) begin
               if (cur_we_nxt) begin
                  state_nxt = ST_SETUP;
               end else begin
                  state_nxt = ST_TURN;
                  cnt_nxt   = TURN_LOAD;
               end
            end
         end
         ST_SETUP: begin
            state_nxt = ST_STROBE;
            cnt_nxt   = STROBE_LOAD;
         end
         ST_TURN: begin
            if (cnt == '0) begin
               state_nxt = ST_STROBE;
               cnt_nxt   = STROBE_LOAD;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         ST_STROBE: begin
            if (cnt == '0) state_nxt = ST_HOLD;
            else           cnt_nxt   = cnt - CNT_W'(1);
         end
         ST_HOLD:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase

      // Pad-side outputs are registered from the state being entered, so they
      // line up with that state's cycle without any input-to-output path.
      oe_nxt    = (state_nxt == ST_SETUP) ||
                  (((state_nxt == ST_STROBE) || (state_nxt == ST_HOLD)) && cur_we_nxt);
      web_nxt   = !((state_nxt == ST_STROBE) && cur_we_nxt);
      oeb_nxt   = !((state_nxt == ST_STROBE) && !cur_we_nxt);
      a_ack_nxt = (state_nxt == ST_HOLD) && (cur_port == PORT_A);
      b_ack_nxt = (state_nxt == ST_HOLD) && (cur_port == PORT_B);
      sample_rd = (state == ST_STROBE) && (cnt == '0) && !cur_we;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         bus_oe_o  <= 1'b0;
         web_o     <= 1'b1;
         oeb_o     <= 1'b1;
         a_ack_o   <= 1'b0;
         b_ack_o   <= 1'b0;
         bus_do_o  <= '0;
         a_rdata_o <= '0;
         b_rdata_o <= '0;
      end else begin
         bus_oe_o <= oe_nxt;
         web_o    <= web_nxt;
         oeb_o    <= oeb_nxt;
         a_ack_o  <= a_ack_nxt;
         b_ack_o  <= b_ack_nxt;
         // Write data is captured at grant and then held until the next write.
         if (gnt[0] && a_we_i)      bus_do_o <= a_wdata_i;
         else if (gnt[1] && b_we_i) bus_do_o <= b_wdata_i;
         if (sample_rd && (cur_port == PORT_A)) a_rdata_o <= bus_di_i;
         if (sample_rd && (cur_port == PORT_B)) b_rdata_o <= bus_di_i;
      end
   end

endmodule

// File: tb/tb_gpio_bus_sched.sv
// Directed vector table plus reset and random-traffic protocol sequences for gpio_bus_sched.
module tb_gpio_bus_sched;

   localparam int W = 34;

   localparam logic [W-1:0] D0 = 34'h0_1111_2222;
   localparam logic [W-1:0] D1 = 34'h2_DEAD_BEEF;
   localparam logic [W-1:0] D2 = 34'h0_CAFE_F00D;
   localparam logic [W-1:0] D3 = 34'h3_0000_00AA;
   localparam logic [W-1:0] D4 = 34'h1_0F0F_0F0F;
   localparam logic [W-1:0] D5 = 34'h2_1357_9BDF;
   localparam logic [W-1:0] R1 = 34'h1_2345_6789;
   localparam logic [W-1:0] R2 = 34'h2_0000_0001;
   localparam logic [W-1:0] R3 = 34'h0_0000_0ABC;
   localparam logic [W-1:0] X1 = 34'h3_FFFF_0000;
   localparam logic [W-1:0] X2 = 34'h1_5555_5555;
   localparam logic [W-1:0] Z  = '0;

   // Control and status shorthands used in the table.
   // ctl = {a_req, a_we, b_req, b_we}; st = {bus_oe, web, oeb, a_ack, b_ack}
   localparam logic [4:0] S_IDLE  = 5'b01100;
   localparam logic [4:0] S_SETUP = 5'b11100;
   localparam logic [4:0] S_WSTB  = 5'b10100;
   localparam logic [4:0] S_WHA   = 5'b11110;
   localparam logic [4:0] S_WHB   = 5'b11101;
   localparam logic [4:0] S_RSTB  = 5'b01000;
   localparam logic [4:0] S_RHA   = 5'b01110;
   localparam logic [4:0] S_RHB   = 5'b01101;

   typedef struct packed {
      logic         oe, web, oeb, a_ack, b_ack;
      logic [W-1:0] dout, a_rd, b_rd;
   } out_t;

   typedef struct {
      logic [3:0]   ctl;
      logic [W-1:0] wa, wb, di;
      out_t         exp;
   } vec_t;

   logic         clk_i = 1'b0;
   logic         rst_i;
   logic         a_req_i, a_we_i, b_req_i, b_we_i;
   logic [W-1:0] a_wdata_i, b_wdata_i, bus_di_i;
   logic         a_ack_o, b_ack_o, bus_oe_o, web_o, oeb_o;
   logic [W-1:0] a_rdata_o, b_rdata_o, bus_do_o;

   int n_total = 0;
   int n_pass  = 0;

   gpio_bus_sched #(.W(W), .STROBE_CYCLES(2), .TURN_CYCLES(1)) dut (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .a_req_i   (a_req_i),
      .a_we_i    (a_we_i),
      .a_wdata_i (a_wdata_i),
      .a_ack_o   (a_ack_o),
      .a_rdata_o (a_rdata_o),
      .b_req_i   (b_req_i),
      .b_we_i    (b_we_i),
      .b_wdata_i (b_wdata_i),
      .b_ack_o   (b_ack_o),
      .b_rdata_o (b_rdata_o),
      .bus_di_i  (bus_di_i),
      .bus_do_o  (bus_do_o),
      .bus_oe_o  (bus_oe_o),
      .web_o     (web_o),
      .oeb_o     (oeb_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic out_t sample();
      return {bus_oe_o, web_o, oeb_o, a_ack_o, b_ack_o, bus_do_o, a_rdata_o, b_rdata_o};
   endfunction

   function automatic vec_t mk(input logic [3:0] ctl, input logic [W-1:0] wa, wb, di,
                               input logic [4:0] st, input logic [W-1:0] dout, ard, brd);
      vec_t v;
      v.ctl = ctl;
      v.wa  = wa;
      v.wb  = wb;
      v.di  = di;
      v.exp = {st, dout, ard, brd};
      return v;
   endfunction

   task automatic apply(input vec_t v);
      {a_req_i, a_we_i, b_req_i, b_we_i} = v.ctl;
      a_wdata_i = v.wa;
      b_wdata_i = v.wb;
      bus_di_i  = v.di;
   endtask

   vec_t vecs[$];

   initial begin
      // Each row: inputs for one cycle, then the outputs expected in the next cycle.
      // Single A write
      vecs.push_back(mk(4'b1100, D1, Z, Z,  S_SETUP, D1, Z, Z));
      vecs.push_back(mk(4'b1100, D1, Z, Z,  S_WSTB,  D1, Z, Z));
      vecs.push_back(mk(4'b1100, D1, Z, Z,  S_WSTB,  D1, Z, Z));
      vecs.push_back(mk(4'b1100, D1, Z, Z,  S_WHA,   D1, Z, Z));
      vecs.push_back(mk(4'b0000, D1, Z, Z,  S_IDLE,  D1, Z, Z));
      // Single B read; bus_di changes right after the sample cycle
      vecs.push_back(mk(4'b0010, Z, Z, R1,  S_IDLE,  D1, Z, Z));
      vecs.push_back(mk(4'b0010, Z, Z, R1,  S_RSTB,  D1, Z, Z));
      vecs.push_back(mk(4'b0010, Z, Z, R1,  S_RSTB,  D1, Z, Z));
      vecs.push_back(mk(4'b0010, Z, Z, R1,  S_RHB,   D1, Z, R1));
      vecs.push_back(mk(4'b0000, Z, Z, X1,  S_IDLE,  D1, Z, R1));
      // Both requesting continuously: A write, B read, A write
      vecs.push_back(mk(4'b1110, D2, Z, X1, S_SETUP, D2, Z, R1));
      vecs.push_back(mk(4'b1110, D2, Z, X1, S_WSTB,  D2, Z, R1));
      vecs.push_back(mk(4'b1110, D2, Z, X1, S_WSTB,  D2, Z, R1));
      vecs.push_back(mk(4'b1110, D2, Z, X1, S_WHA,   D2, Z, R1));
      vecs.push_back(mk(4'b1110, D2, Z, X1, S_IDLE,  D2, Z, R1));
      vecs.push_back(mk(4'b1110, D2, Z, R2, S_IDLE,  D2, Z, R1));
      vecs.push_back(mk(4'b1110, D2, Z, R2, S_RSTB,  D2, Z, R1));
      vecs.push_back(mk(4'b1110, D2, Z, R2, S_RSTB,  D2, Z, R1));
      vecs.push_back(mk(4'b1110, D2, Z, R2, S_RHB,   D2, Z, R2));
      vecs.push_back(mk(4'b1110, D3, Z, X2, S_IDLE,  D2, Z, R2));
      vecs.push_back(mk(4'b1110, D3, Z, X2, S_SETUP, D3, Z, R2));
      vecs.push_back(mk(4'b1110, D3, Z, X2, S_WSTB,  D3, Z, R2));
      vecs.push_back(mk(4'b1110, D3, Z, X2, S_WSTB,  D3, Z, R2));
      vecs.push_back(mk(4'b1110, D3, Z, X2, S_WHA,   D3, Z, R2));
      vecs.push_back(mk(4'b0000, D3, Z, X2, S_IDLE,  D3, Z, R2));
      // A read with req dropped during STROBE, then req held after ack (new write)
      vecs.push_back(mk(4'b1000, Z, Z, Z,   S_IDLE,  D3, Z,  R2));
      vecs.push_back(mk(4'b1000, Z, Z, Z,   S_RSTB,  D3, Z,  R2));
      vecs.push_back(mk(4'b0000, Z, Z, Z,   S_RSTB,  D3, Z,  R2));
      vecs.push_back(mk(4'b0000, Z, Z, R3,  S_RHA,   D3, R3, R2));
      vecs.push_back(mk(4'b1100, D4, Z, X1, S_IDLE,  D3, R3, R2));
      vecs.push_back(mk(4'b1100, D4, Z, X1, S_SETUP, D4, R3, R2));
      vecs.push_back(mk(4'b1100, D4, Z, X1, S_WSTB,  D4, R3, R2));
      vecs.push_back(mk(4'b1100, D4, Z, X1, S_WSTB,  D4, R3, R2));
      vecs.push_back(mk(4'b1100, D4, Z, X1, S_WHA,   D4, R3, R2));
      vecs.push_back(mk(4'b0000, D4, Z, X1, S_IDLE,  D4, R3, R2));
      // B write
      vecs.push_back(mk(4'b0011, D1, D5, X2, S_SETUP, D5, R3, R2));
      vecs.push_back(mk(4'b0011, D1, D5, X2, S_WSTB,  D5, R3, R2));
      vecs.push_back(mk(4'b0011, D1, D5, X2, S_WSTB,  D5, R3, R2));
      vecs.push_back(mk(4'b0011, D1, D5, X2, S_WHB,   D5, R3, R2));
      vecs.push_back(mk(4'b0000, D1, D5, X2, S_IDLE,  D5, R3, R2));

      rst_i = 1'b1;
      apply(mk(4'b0000, Z, Z, Z, S_IDLE, Z, Z, Z));
      repeat (2) tick();
      check("reset_init", sample(), {S_IDLE, Z, Z, Z});
      rst_i = 1'b0;

      // Reset asserted while a write strobe is low aborts it without an ack
      apply(mk(4'b1100, D0, Z, Z, S_IDLE, Z, Z, Z));
      tick();
      check("rst_seq_setup", {bus_oe_o, bus_do_o}, {1'b1, D0});
      tick();
      check("rst_seq_strobe", web_o, 1'b0);
      rst_i   = 1'b1;
      a_req_i = 1'b0;
      tick();
      check("rst_mid_strobe", sample(), {S_IDLE, Z, Z, Z});
      rst_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("rst_idle%0d", i), sample(), {S_IDLE, Z, Z, Z});
      end

      foreach (vecs[i]) begin
         apply(vecs[i]);
         tick();
         check($sformatf("vec%0d", i), sample(), vecs[i].exp);
      end

      // Random traffic with protocol invariants checked every cycle
      begin
         int           n_acks = 0;
         logic         prev_web_low = 1'b0;
         logic         prev_oe = 1'b0;
         logic [W-1:0] prev_do = '0;
         for (int c = 0; c < 10000; c++) begin
            a_req_i   = ($urandom_range(0, 3) != 0);
            a_we_i    = 1'($urandom_range(0, 1));
            b_req_i   = ($urandom_range(0, 3) != 0);
            b_we_i    = 1'($urandom_range(0, 1));
            a_wdata_i = W'({$urandom(), $urandom()});
            b_wdata_i = W'({$urandom(), $urandom()});
            bus_di_i  = W'({$urandom(), $urandom()});
            tick();
            check("inv_strobes", web_o | oeb_o, 1'b1);
            check("inv_oe_read", !(bus_oe_o && !oeb_o), 1'b1);
            if (prev_web_low && !web_o)
               check("inv_web_stable", {bus_oe_o, bus_do_o}, {prev_oe, prev_do});
            if (a_ack_o || b_ack_o) n_acks++;
            prev_web_low = !web_o;
            prev_oe      = bus_oe_o;
            prev_do      = bus_do_o;
         end
         check("rand_traffic_acks", n_acks > 1000, 1'b1);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/gpio_bus_sched.md
# gpio_bus_sched

Transaction scheduler for the 34-bit shared GPIO pad bus of `fpga_wrapper`. Two internal requesters (port A, port B) issue single-word read or write transactions; the block arbitrates round-robin, then sequences the pad-level protocol:

- active-low write strobe `web`;
- active-low output strobe `oeb`;
- pad tristate enable;
- turnaround and hold timing.

It sits between core logic and the pad ring, replacing direct drive of `gpio[35:34]` and the `gpio[33:0]` direction control.

## Interface

**Parameters**
- `W`, 34: pad data bus width.
- `STROBE_CYCLES`, 2: cycles a strobe is held low (≥1).
- `TURN_CYCLES`, 1: bus-release cycles before a read strobe (≥1).

**Ports** (clock and reset first)
- `clk_i` in 1: single clock. All logic is on the rising edge.
- `rst_i` in 1: synchronous, active-high reset.
- `a_req_i` in 1: port A request. Held until `a_ack_o`.
- `a_we_i` in 1: port A, 1 = write, 0 = read. Sampled at grant.
- `a_wdata_i` in W: port A write data. Sampled at grant.
- `a_ack_o` out 1: one-cycle completion pulse.
- `a_rdata_o` out W: read result. Valid with `a_ack_o` and held until the next A read completes.
- `b_req_i`, `b_we_i`, `b_wdata_i`, `b_ack_o`, `b_rdata_o`: identical for port B.
- `bus_di_i` in W: pad input data.
- `bus_do_o` out W: pad output data.
- `bus_oe_o` out 1: 1 = pads drive `bus_do_o`.
- `web_o` out 1: write strobe, active low.
- `oeb_o` out 1: output (read) strobe, active low.

## Operation

**States:** IDLE, SETUP, TURN, STROBE, HOLD.

**IDLE**
- If any request is present, the winner is chosen and `we`/`wdata` are latched.
- Write goes to SETUP; read goes to TURN.
- Round-robin: on simultaneous requests, the port not granted last wins.
- The last-grant register resets to B, so A wins the first tie.

**Write path**
- SETUP (1 cycle): `bus_oe_o`=1, `bus_do_o`=wdata, strobes high.
- STROBE (`STROBE_CYCLES`): `web_o`=0, data still driven.
- HOLD (1 cycle): `web_o`=1, data still driven, ack pulses. Then IDLE.
- `bus_oe_o` drops on IDLE entry.

**Read path**
- TURN (`TURN_CYCLES`): `bus_oe_o`=0, strobes high.
- STROBE (`STROBE_CYCLES`): `oeb_o`=0. `bus_di_i` is sampled on the last strobe cycle.
- HOLD (1 cycle): `oeb_o`=1, ack pulses, rdata updated. Then IDLE.

**Invariants**
- `web_o` and `oeb_o` are never both low.
- `bus_oe_o`=0 whenever `oeb_o`=0.
- `bus_oe_o` and `bus_do_o` are stable throughout any `web_o`-low window.

**Boundary conditions**
- Requester drops req mid-transaction: the transaction still completes and ack still pulses.
- Req still high in the IDLE cycle after ack: treated as a new request and re-arbitrated.
- Both ports requesting continuously: strict alternation.
- `bus_do_o` holds its last write value when not driving.
- `rdata` of the non-granted port is unchanged.

## Timing

**Reset values** (next edge with `rst_i`=1, regardless of state; reset mid-transaction aborts it with no ack):
- state IDLE, last-grant B;
- `bus_oe_o`=0, `web_o`=1, `oeb_o`=1;
- `bus_do_o`=0, `a_rdata_o`=`b_rdata_o`=0;
- `a_ack_o`=`b_ack_o`=0.

**Latency**, with request seen in IDLE at cycle 0:
- Write: ack at cycle 2+`STROBE_CYCLES` (4 with defaults).
- Read: ack at cycle 2+`TURN_CYCLES`+`STROBE_CYCLES`−1 (4 with defaults).
- Minimum transaction spacing: ack cycle + 1 IDLE cycle.

**Output registration:** all outputs are registered; no combinational path from inputs to outputs.

## Structure

- **Package `gpio_bus_pkg`:** state enum, default `W`, `STROBE_CYCLES`, `TURN_CYCLES` constants.
- **Sub-module `gpio_bus_rr_arb`:** 2-way round-robin arbiter. Inputs are the req pair and an enable (IDLE); outputs are a one-hot grant plus the last-grant register.
- **In `gpio_bus_sched`:** a single down-counter shared by the TURN and STROBE phases.

## Test plan

- **Reset values:** assert `rst_i` mid-STROBE of a write. Next cycle: `web_o`=1, `bus_oe_o`=0, no ack. Then idle outputs match the reset values.
- **Single A write:** A write 34'h2_DEAD_BEEF. Expect:
  - cycle 1: `bus_oe_o`=1 with the data;
  - cycles 2–3: `web_o`=0;
  - cycle 4: `a_ack_o`=1;
  - `oeb_o` stays 1 throughout.
- **Single B read:** `bus_di_i`=34'h1_2345_6789. Expect:
  - cycle 1: `bus_oe_o`=0;
  - cycles 2–3: `oeb_o`=0;
  - cycle 4: `b_ack_o`=1 and `b_rdata_o`=34'h1_2345_6789.
- **Simultaneous requests after reset:** A is served first, then B, and acks alternate under continuous requests. Change `bus_di_i` after the sample cycle and confirm rdata is unaffected.
- **Early drop and re-request:** A drops req during STROBE; ack still pulses. Req held after ack produces a second transaction starting one IDLE cycle later.
- **Protocol checker** on random traffic over 10k cycles: strobes never both low, and `bus_oe_o` never 1 while `oeb_o`=0.
